// File: rtl/seq_demux_1x8.sv
// seq_demux_1x8: registered 1-to-8 demultiplexer / serial-to-parallel assembler.
// One din bit per accepted beat lands in lane idx (auto counter or external sel).
// The finished 8-bit word is offered on a valid/ready output.
// Optional parity check: define SEQ_DEMUX_PARITY_EN to add din_par / par_err.
module seq_demux_1x8 #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
`ifdef SEQ_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [N-1:0]     lane_strobe
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     dout_q, dout_d;
  logic [N-1:0]     strobe_q, strobe_d;
  logic [SEL_W-1:0] idx;
  logic             beat;
`ifdef SEQ_DEMUX_PARITY_EN
  logic             par_acc_q, par_acc_d;
  logic             par_err_q, par_err_d;
`endif

  // Ready is held low while reset is asserted, so no beat can be taken then.
  assign din_ready   = rst_n && (state_q == COLLECT);
  assign dout_valid  = (state_q == HOLD);
  assign dout        = dout_q;
  assign lane_strobe = strobe_q;
  assign beat        = din_valid && din_ready;
  assign idx         = mode ? sel : cnt_q;
`ifdef SEQ_DEMUX_PARITY_EN
  assign par_err     = par_err_q;
`endif

  // Next-state logic: clear wins, then beat capture (COLLECT) or handshake (HOLD).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    dout_d   = dout_q;
    strobe_d = '0;
`ifdef SEQ_DEMUX_PARITY_EN
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
`endif
    if (clear) begin
      state_d = COLLECT;
      cnt_d   = '0;
      mask_d  = '0;
      dout_d  = '0;
`ifdef SEQ_DEMUX_PARITY_EN
      par_acc_d = 1'b0;
      par_err_d = 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (beat) begin
            dout_d[idx] = din;
            mask_d[idx] = 1'b1;
            strobe_d    = {{(N-1){1'b0}}, 1'b1} << idx;
            if (!mode) begin
              cnt_d = cnt_q + {{(SEL_W-1){1'b0}}, 1'b1};
            end
`ifdef SEQ_DEMUX_PARITY_EN
            par_acc_d = par_acc_q ^ din;
`endif
            // Word completes only once every distinct lane has been written.
            if (&mask_d) begin
              state_d = HOLD;
`ifdef SEQ_DEMUX_PARITY_EN
              par_err_d = (par_acc_d != din_par);
`endif
            end
          end
        end
        HOLD: begin
          // dout is kept after the handshake and overwritten lane by lane.
          if (dout_ready) begin
            state_d = COLLECT;
            cnt_d   = '0;
            mask_d  = '0;
`ifdef SEQ_DEMUX_PARITY_EN
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
`endif
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      mask_q   <= '0;
      dout_q   <= '0;
      strobe_q <= '0;
`ifdef SEQ_DEMUX_PARITY_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
`ifdef SEQ_DEMUX_PARITY_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_demux_1x8.sv
// Directed testbench for seq_demux_1x8; parity checks built with SEQ_DEMUX_PARITY_EN.
module tb_seq_demux_1x8;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] lane_strobe;
`ifdef SEQ_DEMUX_PARITY_EN
  logic       din_par;
  logic       par_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] pat;
  logic [2:0] sels [9] = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

  seq_demux_1x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .mode        (mode),
    .sel         (sel),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
`ifdef SEQ_DEMUX_PARITY_EN
    .din_par     (din_par),
    .par_err     (par_err),
`endif
    .lane_strobe (lane_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted-beat attempt; returns 1 ns after the capturing edge.
  task automatic send(input logic b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input string tag);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk(tag, {7'd0, dout_valid}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; din = 1'b0; din_valid = 1'b0;
    mode = 1'b0; sel = 3'd0; dout_ready = 1'b0;
`ifdef SEQ_DEMUX_PARITY_EN
    din_par = 1'b0;
`endif
    #3;
    chk("rst_dout",   dout, 8'h00);
    chk("rst_valid",  {7'd0, dout_valid}, 8'd0);
    chk("rst_ready",  {7'd0, din_ready}, 8'd0);
    chk("rst_strobe", lane_strobe, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_ready", {7'd0, din_ready}, 8'd1);

    // Auto-sequenced word 0x4D, no gaps
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      send(pat[i]);
      chk("t1_strobe", lane_strobe, 8'(1 << i));
      if (i < 7) chk("t1_novalid", {7'd0, dout_valid}, 8'd0);
    end
    chk("t1_valid", {7'd0, dout_valid}, 8'd1);
    chk("t1_dout",  dout, 8'h4D);
    chk("t1_ready", {7'd0, din_ready}, 8'd0);
    step();
    chk("t1_hold_valid",  {7'd0, dout_valid}, 8'd1);
    chk("t1_hold_dout",   dout, 8'h4D);
    chk("t1_hold_strobe", lane_strobe, 8'h00);
    chk("t1_hold_ready",  {7'd0, din_ready}, 8'd0);

    // Handshake with a simultaneous beat: beat must be dropped
    dout_ready = 1'b1; din_valid = 1'b1; din = 1'b1;
    step();
    dout_ready = 1'b0; din_valid = 1'b0;
    chk("t2_valid",  {7'd0, dout_valid}, 8'd0);
    chk("t2_ready",  {7'd0, din_ready}, 8'd1);
    chk("t2_strobe", lane_strobe, 8'h00);
    chk("t2_dout",   dout, 8'h4D);
    send(1'b0);
    chk("t2_lane0", lane_strobe, 8'h01);
    chk("t2_dout0", dout, 8'h4C);
    for (int i = 1; i < 8; i++) send(1'b1);
    chk("t2_valid2", {7'd0, dout_valid}, 8'd1);
    chk("t2_dout2",  dout, 8'hFE);
    handshake("t2_hs");

    // Addressed mode with a rewrite of lane 3
    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sel = sels[i];
      send((i == 2) ? 1'b0 : 1'b1);
      chk("t3_strobe", lane_strobe, 8'(1 << sels[i]));
      if (i == 7) chk("t3_novalid8", {7'd0, dout_valid}, 8'd0);
    end
    chk("t3_valid", {7'd0, dout_valid}, 8'd1);
    chk("t3_dout",  dout, 8'hF7);
    handshake("t3_hs");
    mode = 1'b0;

    // Partial word then clear with a beat
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("t4_partial", dout, 8'hFF);
    clear = 1'b1; din_valid = 1'b1; din = 1'b1;
    step();
    clear = 1'b0; din_valid = 1'b0;
    chk("t4_clr_dout",   dout, 8'h00);
    chk("t4_clr_valid",  {7'd0, dout_valid}, 8'd0);
    chk("t4_clr_strobe", lane_strobe, 8'h00);
    chk("t4_clr_ready",  {7'd0, din_ready}, 8'd1);
    pat = 8'h96;
    for (int i = 0; i < 8; i++) begin
      send(pat[i]);
      chk("t4_strobe", lane_strobe, 8'(1 << i));
      if (i < 7) chk("t4_novalid", {7'd0, dout_valid}, 8'd0);
    end
    chk("t4_valid", {7'd0, dout_valid}, 8'd1);
    chk("t4_dout",  dout, 8'h96);

    // Asynchronous reset in HOLD
    #2 rst_n = 1'b0;
    #1;
    chk("t5h_dout",   dout, 8'h00);
    chk("t5h_valid",  {7'd0, dout_valid}, 8'd0);
    chk("t5h_ready",  {7'd0, din_ready}, 8'd0);
    chk("t5h_strobe", lane_strobe, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("t5h_rel_ready", {7'd0, din_ready}, 8'd1);

    // Asynchronous reset mid-word
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("t5w_pre_dout",   dout, 8'h07);
    chk("t5w_pre_strobe", lane_strobe, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("t5w_dout",   dout, 8'h00);
    chk("t5w_strobe", lane_strobe, 8'h00);
    chk("t5w_ready",  {7'd0, din_ready}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b1);
    chk("t5w_restart_strobe", lane_strobe, 8'h01);
    chk("t5w_restart_dout",   dout, 8'h01);

`ifdef SEQ_DEMUX_PARITY_EN
    clear = 1'b1;
    step();
    clear = 1'b0;
    pat = 8'h4D;
    din_par = 1'b0;
    for (int i = 0; i < 8; i++) send(pat[i]);
    chk("p_valid0", {7'd0, dout_valid}, 8'd1);
    chk("p_err0",   {7'd0, par_err}, 8'd0);
    handshake("p_hs0");
    din_par = 1'b1;
    for (int i = 0; i < 8; i++) send(pat[i]);
    chk("p_valid1", {7'd0, dout_valid}, 8'd1);
    chk("p_err1",   {7'd0, par_err}, 8'd1);
    handshake("p_hs1");
    chk("p_err_clr", {7'd0, par_err}, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
